// File: rtl/snoopsplit_nway.sv
// snoopsplit_nway: steers each whole packet from one upstream writer to one of N_CHAN VM memories.
// A single arbiter stage (round-robin or fixed priority) picks a ready channel and tags each completed packet.
module snoopsplit_nway #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int N_CHAN     = 4,
  parameter int ARB_MODE   = 0,
  parameter int SEL_WIDTH  = $clog2(N_CHAN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_en,
  input  logic                         done,
  output logic                         mem_ready,
  output logic [N_CHAN*ADDR_WIDTH-1:0] wr_addr_out,
  output logic [N_CHAN*DATA_WIDTH-1:0] wr_data_out,
  output logic [N_CHAN-1:0]            wr_en_out,
  output logic [N_CHAN-1:0]            done_out,
  input  logic [N_CHAN-1:0]            mem_ready_in,
  output logic [SEL_WIDTH-1:0]         choice,
  output logic                         choice_valid
);

  // state  | meaning
  // IDLE   | no channel granted; arbitrate among ready channels
  // WRITE  | packet in flight to channel sel; upstream sees mem_ready
  // SETTLE | one dead cycle so the just-filled VM can drop its ready
  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;

  state_t               state, state_nxt;
  logic [SEL_WIDTH-1:0] sel, last_grant, pick, cand;

  // Loops run from the lowest-priority candidate upward so the last hit is the winner.
  always_comb begin
    pick = '0;
    cand = '0;
    if (ARB_MODE == 1) begin
      for (int i = N_CHAN - 1; i >= 0; i--) begin
        cand = SEL_WIDTH'(i);
        if (mem_ready_in[cand]) pick = cand;
      end
    end else begin
      for (int k = N_CHAN; k >= 1; k--) begin
        cand = SEL_WIDTH'((int'(last_grant) + k) % N_CHAN);
        if (mem_ready_in[cand]) pick = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_ready = 1'b0;
    wr_en_out = '0;
    done_out  = '0;
    case (state)
      IDLE: begin
        if (|mem_ready_in) state_nxt = WRITE;
      end
      WRITE: begin
        mem_ready      = 1'b1;
        wr_en_out[sel] = wr_en;
        done_out[sel]  = done;
        if (done) state_nxt = SETTLE;
      end
      SETTLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign wr_addr_out = {N_CHAN{wr_addr}};
  assign wr_data_out = {N_CHAN{wr_data}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= '0;
      last_grant   <= SEL_WIDTH'(N_CHAN - 1);
      choice       <= '0;
      choice_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      choice_valid <= 1'b0;
      if (state == IDLE && (|mem_ready_in)) sel <= pick;
      if (state == WRITE && done) begin
        last_grant   <= sel;
        choice       <= sel;
        choice_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snoopsplit_nway.sv
// Bench for snoopsplit_nway: three instances (4-way round-robin, 4-way fixed priority, 3-way round-robin)
// driven by a directed packet table, hand sequences for idle/reset corners, and random packets vs a model.
module tb_snoopsplit_nway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  addr;
  logic [63:0] data;
  logic [2:0]  we, dn;
  logic [15:0] rdy [3];

  logic [39:0]  a_ao, b_ao;
  logic [255:0] a_do, b_do;
  logic [3:0]   a_we, a_dn, b_we, b_dn;
  logic [1:0]   a_ch, b_ch, c_ch;
  logic         a_cv, a_mr, b_cv, b_mr, c_cv, c_mr;
  logic [29:0]  c_ao;
  logic [191:0] c_do;
  logic [2:0]   c_we, c_dn;

  always #5 clk = ~clk;

  snoopsplit_nway #(.N_CHAN(4), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_addr(addr), .wr_data(data), .wr_en(we[0]), .done(dn[0]),
    .mem_ready(a_mr), .wr_addr_out(a_ao), .wr_data_out(a_do), .wr_en_out(a_we), .done_out(a_dn),
    .mem_ready_in(rdy[0][3:0]), .choice(a_ch), .choice_valid(a_cv));

  snoopsplit_nway #(.N_CHAN(4), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_addr(addr), .wr_data(data), .wr_en(we[1]), .done(dn[1]),
    .mem_ready(b_mr), .wr_addr_out(b_ao), .wr_data_out(b_do), .wr_en_out(b_we), .done_out(b_dn),
    .mem_ready_in(rdy[1][3:0]), .choice(b_ch), .choice_valid(b_cv));

  snoopsplit_nway #(.N_CHAN(3), .ARB_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_addr(addr), .wr_data(data), .wr_en(we[2]), .done(dn[2]),
    .mem_ready(c_mr), .wr_addr_out(c_ao), .wr_data_out(c_do), .wr_en_out(c_we), .done_out(c_dn),
    .mem_ready_in(rdy[2][2:0]), .choice(c_ch), .choice_valid(c_cv));

  logic [15:0] weo_v [3];
  logic [15:0] doo_v [3];
  logic [3:0]  ch_v  [3];
  logic [2:0]  mr_v, cv_v;

  assign weo_v[0] = {12'b0, a_we};
  assign weo_v[1] = {12'b0, b_we};
  assign weo_v[2] = {13'b0, c_we};
  assign doo_v[0] = {12'b0, a_dn};
  assign doo_v[1] = {12'b0, b_dn};
  assign doo_v[2] = {13'b0, c_dn};
  assign ch_v[0]  = {2'b0, a_ch};
  assign ch_v[1]  = {2'b0, b_ch};
  assign ch_v[2]  = {2'b0, c_ch};
  assign mr_v     = {c_mr, b_mr, a_mr};
  assign cv_v     = {c_cv, b_cv, a_cv};

  int checks = 0;
  int errors = 0;
  int lg [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbiter: scan channels in the order the selection rule defines.
  function automatic int model_pick(input int inst, input logic [15:0] mask);
    int n;
    int c;
    n = (inst == 2) ? 3 : 4;
    if (inst == 1) begin
      for (int i = 0; i < n; i++) if (mask[i]) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        c = (lg[inst] + k) % n;
        if (mask[c]) return c;
      end
    end
    return -1;
  endfunction

  function automatic bit bcast_ok(input int inst);
    case (inst)
      0:       return (a_ao == {4{addr}}) && (a_do == {4{data}});
      1:       return (b_ao == {4{addr}}) && (b_do == {4{data}});
      default: return (c_ao == {3{addr}}) && (c_do == {3{data}});
    endcase
  endfunction

  task automatic wait_grant(input int inst, output bit ok);
    int t;
    t = 0;
    while (mr_v[inst] !== 1'b1 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = (mr_v[inst] === 1'b1);
    if (!ok) chk("grant_timeout", {63'b0, mr_v[inst]}, 64'd1);
  endtask

  task automatic send_packet(input int inst, input int nwr, input bit same,
                             input logic [15:0] mid, input logic [15:0] settle, input int exp);
    logic [15:0] onehot;
    bit ok;
    onehot = 16'(1) << exp;
    wait_grant(inst, ok);
    if (!ok) return;
    for (int w = 0; w < nwr; w++) begin
      if (w > 0) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
          we[inst] = 1'b0;
          dn[inst] = 1'b0;
          #1;
          chk("gap_wr_en", 64'(weo_v[inst]), 64'd0);
          chk("gap_mem_ready", 64'(mr_v[inst]), 64'd1);
          @(negedge clk);
        end
      end
      if (w == 0) rdy[inst] = mid;
      addr = 10'($urandom);
      data = {$urandom, $urandom};
      we[inst] = 1'b1;
      dn[inst] = same && (w == nwr - 1);
      #1;
      chk("wr_en_route", 64'(weo_v[inst]), 64'(onehot));
      chk("done_route", 64'(doo_v[inst]), dn[inst] ? 64'(onehot) : 64'd0);
      chk("mem_ready_write", 64'(mr_v[inst]), 64'd1);
      chk("addr_data_bcast", 64'(bcast_ok(inst)), 64'd1);
    end
    if (!same) begin
      @(negedge clk);
      we[inst] = 1'b0;
      dn[inst] = 1'b1;
      #1;
      chk("done_route", 64'(doo_v[inst]), 64'(onehot));
      chk("done_no_wr", 64'(weo_v[inst]), 64'd0);
    end
    @(negedge clk);
    we[inst]  = 1'b1;
    dn[inst]  = 1'b0;
    rdy[inst] = settle;
    #1;
    chk("choice_valid", 64'(cv_v[inst]), 64'd1);
    chk("choice", 64'(ch_v[inst]), 64'(exp));
    chk("settle_mem_ready", 64'(mr_v[inst]), 64'd0);
    chk("settle_no_wr", 64'(weo_v[inst]), 64'd0);
    chk("settle_no_done", 64'(doo_v[inst]), 64'd0);
    lg[inst] = exp;
    @(negedge clk);
    we[inst] = 1'b0;
    #1;
    chk("choice_valid_pulse", 64'(cv_v[inst]), 64'd0);
    chk("idle_mem_ready", 64'(mr_v[inst]), 64'd0);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] mid;
    logic [15:0] settle;
    int          nwr;
    bit          same;
    int          exp;
  } vec_t;

  vec_t tbl [$];

  initial begin
    bit ok;
    int inst, n, exp;
    logic [15:0] mask;

    tbl.push_back('{0, 16'hF, 16'hF, 10, 1'b0, 0});
    tbl.push_back('{0, 16'hF, 16'hF, 10, 1'b0, 1});
    tbl.push_back('{0, 16'hF, 16'hF, 10, 1'b0, 2});
    tbl.push_back('{0, 16'hF, 16'hF, 10, 1'b0, 3});
    tbl.push_back('{0, 16'hC, 16'hC, 3,  1'b0, 0});
    tbl.push_back('{0, 16'hC, 16'h1, 3,  1'b0, 2});
    tbl.push_back('{0, 16'h1, 16'h0, 3,  1'b0, 0});
    tbl.push_back('{1, 16'hF, 16'hF, 4,  1'b0, 0});
    tbl.push_back('{1, 16'hF, 16'hF, 4,  1'b0, 0});
    tbl.push_back('{1, 16'hF, 16'hE, 4,  1'b0, 0});
    tbl.push_back('{1, 16'hE, 16'h0, 4,  1'b0, 1});
    tbl.push_back('{2, 16'h7, 16'h7, 4,  1'b0, 0});
    tbl.push_back('{2, 16'h7, 16'h7, 4,  1'b0, 1});
    tbl.push_back('{2, 16'h7, 16'h7, 4,  1'b0, 2});
    tbl.push_back('{2, 16'h7, 16'h0, 3,  1'b1, 0});

    rst_n = 1'b0;
    addr = '0;
    data = '0;
    we = '0;
    dn = '0;
    rdy[0] = 16'hF;
    rdy[1] = 16'hF;
    rdy[2] = 16'h7;
    lg[0] = 3;
    lg[1] = 3;
    lg[2] = 2;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mem_ready", 64'(mr_v[i]), 64'd0);
      chk("rst_choice", 64'(ch_v[i]), 64'd0);
      chk("rst_choice_valid", 64'(cv_v[i]), 64'd0);
      chk("rst_wr_en_out", 64'(weo_v[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      send_packet(tbl[r].inst, tbl[r].nwr, tbl[r].same, tbl[r].mid, tbl[r].settle, tbl[r].exp);
      if (tbl[r].settle != 16'h0) begin
        @(negedge clk);
        #1;
        chk("regrant_latency", 64'(mr_v[tbl[r].inst]), 64'd1);
      end
    end

    // Nothing ready: block must stay idle and swallow upstream strobes.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      we[0] = 1'b1;
      dn[0] = (c == 2);
      #1;
      chk("noready_mem_ready", 64'(a_mr), 64'd0);
      chk("noready_wr_en", 64'(a_we), 64'd0);
      chk("noready_done", 64'(a_dn), 64'd0);
      chk("noready_choice_valid", 64'(a_cv), 64'd0);
    end
    @(negedge clk);
    we[0] = 1'b0;
    dn[0] = 1'b0;
    rdy[0] = 16'h2;
    #1;
    chk("late_ready_idle", 64'(a_mr), 64'd0);
    @(negedge clk);
    #1;
    chk("late_ready_grant", 64'(a_mr), 64'd1);
    send_packet(0, 3, 1'b0, 16'h2, 16'h0, 1);

    // Reset in the middle of a packet on channel 2.
    rdy[0] = 16'h4;
    wait_grant(0, ok);
    if (ok) begin
      for (int w = 0; w < 3; w++) begin
        if (w > 0) @(negedge clk);
        we[0] = 1'b1;
        #1;
        chk("pre_reset_wr_en", 64'(a_we), 64'h4);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midpkt_rst_mem_ready", 64'(mr_v[i]), 64'd0);
      chk("midpkt_rst_wr_en", 64'(weo_v[i]), 64'd0);
      chk("midpkt_rst_choice", 64'(ch_v[i]), 64'd0);
      chk("midpkt_rst_choice_valid", 64'(cv_v[i]), 64'd0);
    end
    lg[0] = 3;
    lg[1] = 3;
    lg[2] = 2;
    @(negedge clk);
    we[0] = 1'b0;
    rdy[0] = 16'hF;
    rst_n = 1'b1;
    send_packet(0, 2, 1'b0, 16'hF, 16'h0, 0);

    // Random packets against the reference arbiter.
    for (int p = 0; p < 30; p++) begin
      inst = $urandom_range(0, 2);
      n = (inst == 2) ? 3 : 4;
      mask = 16'($urandom_range(1, (1 << n) - 1));
      exp = model_pick(inst, mask);
      @(negedge clk);
      rdy[inst] = mask;
      send_packet(inst, $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                  16'($urandom) & 16'((1 << n) - 1), 16'h0, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
